// File: rtl/e203_soc_pad_ctrl_if.sv
// Register bus between the pad control shell and its host.
// The slave side always accepts, so bus_ready is only informational.
interface e203_soc_pad_ctrl_if;
   logic        bus_valid;
   logic        bus_write;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   modport master (
      output bus_valid,
      output bus_write,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata,
      input  bus_ready
   );

   modport slave (
      input  bus_valid,
      input  bus_write,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata,
      output bus_ready
   );
endinterface

// File: rtl/e203_soc_pad_ctrl.sv
// Pad-facing control shell of the E203 SoC: reset sync, boot straps, wakeup,
// GPIO A/B pad registers on a small register bus, and JTAG/QSPI pass-through.
module e203_soc_pad_ctrl #(
   parameter int          GPIO_W    = 32,
   parameter logic [31:0] ROM_VEC   = 32'h8000_0000,
   parameter logic [31:0] FLASH_VEC = 32'h2000_0000
) (
   input  logic              hfextclk,
   input  logic              io_pads_aon_erst_n_i_ival,
   e203_soc_pad_ctrl_if.slave bus,

   output logic              hfxoscen,
   output logic              lfxoscen,

   input  logic              io_pads_bootrom_n_i_ival,
   input  logic              io_pads_dbgmode0_n_i_ival,
   input  logic              io_pads_dbgmode1_n_i_ival,
   input  logic              io_pads_dbgmode2_n_i_ival,

   input  logic              io_pads_aon_pmu_dwakeup_n_i_ival,
   output logic              io_pads_aon_pmu_vddpaden_o_oval,
   output logic              io_pads_aon_pmu_padrst_o_oval,

   input  logic [GPIO_W-1:0] io_pads_gpioA_i_ival,
   input  logic [GPIO_W-1:0] io_pads_gpioB_i_ival,
   output logic [GPIO_W-1:0] io_pads_gpioA_o_oval,
   output logic [GPIO_W-1:0] io_pads_gpioB_o_oval,
   output logic [GPIO_W-1:0] io_pads_gpioA_o_oe,
   output logic [GPIO_W-1:0] io_pads_gpioB_o_oe,

   input  logic              io_pads_jtag_TCK_i_ival,
   input  logic              io_pads_jtag_TMS_i_ival,
   input  logic              io_pads_jtag_TDI_i_ival,
   output logic              io_pads_jtag_TDO_o_oval,
   output logic              io_pads_jtag_TDO_o_oe,
   output logic              jtag_tck,
   output logic              jtag_tms,
   output logic              jtag_tdi,
   input  logic              jtag_tdo,
   input  logic              jtag_tdo_oe,

   output logic              io_pads_qspi0_sck_o_oval,
   output logic              io_pads_qspi0_cs_0_o_oval,
   input  logic              io_pads_qspi0_dq_0_i_ival,
   input  logic              io_pads_qspi0_dq_1_i_ival,
   input  logic              io_pads_qspi0_dq_2_i_ival,
   input  logic              io_pads_qspi0_dq_3_i_ival,
   output logic              io_pads_qspi0_dq_0_o_oval,
   output logic              io_pads_qspi0_dq_1_o_oval,
   output logic              io_pads_qspi0_dq_2_o_oval,
   output logic              io_pads_qspi0_dq_3_o_oval,
   output logic              io_pads_qspi0_dq_0_o_oe,
   output logic              io_pads_qspi0_dq_1_o_oe,
   output logic              io_pads_qspi0_dq_2_o_oe,
   output logic              io_pads_qspi0_dq_3_o_oe,
   input  logic              qspi_sck,
   input  logic              qspi_cs,
   input  logic [3:0]        qspi_dq_o,
   input  logic [3:0]        qspi_dq_oe,
   output logic [3:0]        qspi_dq_i,

   output logic              sys_rst_n,
   output logic [31:0]       reset_vector,
   output logic [2:0]        dbg_mode,
   output logic              wakeup
);

   localparam logic [2:0] A_GPIOA_OUT = 3'd0;
   localparam logic [2:0] A_GPIOA_OE  = 3'd1;
   localparam logic [2:0] A_GPIOA_IN  = 3'd2;
   localparam logic [2:0] A_GPIOB_OUT = 3'd3;
   localparam logic [2:0] A_GPIOB_OE  = 3'd4;
   localparam logic [2:0] A_GPIOB_IN  = 3'd5;
   localparam logic [2:0] A_MODE      = 3'd6;

   logic              w_rstN;
   logic [1:0]        r_rstSync;
   logic [1:0]        r_wakeSync;
   logic              r_strapValid;
   logic              r_bootromN;
   logic [2:0]        r_dbgN;
   logic              w_bootromN;
   logic [2:0]        w_dbgN;
   logic [GPIO_W-1:0] r_gpioAOut;
   logic [GPIO_W-1:0] r_gpioAOe;
   logic [GPIO_W-1:0] r_gpioBOut;
   logic [GPIO_W-1:0] r_gpioBOe;
   logic [GPIO_W-1:0] r_gpioAMeta;
   logic [GPIO_W-1:0] r_gpioAIn;
   logic [GPIO_W-1:0] r_gpioBMeta;
   logic [GPIO_W-1:0] r_gpioBIn;
   logic [31:0]       r_rdata;
   logic [31:0]       w_readData;
   logic [2:0]        w_wordAddr;
   logic              w_wrEn;
   logic              w_rdEn;
   logic              w_unused;

   assign w_rstN     = io_pads_aon_erst_n_i_ival;
   assign w_wordAddr = bus.bus_addr[4:2];
   assign w_unused   = &{1'b0, bus.bus_addr[1:0]};

   // Reset assert is immediate; release reaches the subsystem after two edges.
   always_ff @(posedge hfextclk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_rstSync <= 2'b00;
      end else begin
         r_rstSync <= {r_rstSync[0], 1'b1};
      end
   end

   assign sys_rst_n                       = r_rstSync[1];
   assign io_pads_aon_pmu_padrst_o_oval   = ~r_rstSync[1];
   assign io_pads_aon_pmu_vddpaden_o_oval = 1'b1;
   assign hfxoscen                        = 1'b1;
   assign lfxoscen                        = 1'b1;

   always_ff @(posedge hfextclk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_wakeSync <= 2'b00;
      end else begin
         r_wakeSync <= {r_wakeSync[0], ~io_pads_aon_pmu_dwakeup_n_i_ival};
      end
   end

   assign wakeup = r_wakeSync[1];

   // Straps are sampled once, on the first clock the subsystem is out of reset.
   always_ff @(posedge hfextclk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_strapValid <= 1'b0;
         r_bootromN   <= 1'b0;
         r_dbgN       <= 3'b111;
      end else if (r_rstSync[1] && !r_strapValid) begin
         r_strapValid <= 1'b1;
         r_bootromN   <= io_pads_bootrom_n_i_ival;
         r_dbgN       <= {io_pads_dbgmode2_n_i_ival,
                          io_pads_dbgmode1_n_i_ival,
                          io_pads_dbgmode0_n_i_ival};
      end
   end

   assign w_bootromN   = r_strapValid ? r_bootromN : io_pads_bootrom_n_i_ival;
   assign w_dbgN       = r_strapValid ? r_dbgN
                                      : {io_pads_dbgmode2_n_i_ival,
                                         io_pads_dbgmode1_n_i_ival,
                                         io_pads_dbgmode0_n_i_ival};
   assign reset_vector = w_bootromN ? FLASH_VEC : ROM_VEC;
   assign dbg_mode     = ~w_dbgN;

   always_ff @(posedge hfextclk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_gpioAMeta <= '0;
         r_gpioAIn   <= '0;
         r_gpioBMeta <= '0;
         r_gpioBIn   <= '0;
      end else begin
         r_gpioAMeta <= io_pads_gpioA_i_ival;
         r_gpioAIn   <= r_gpioAMeta;
         r_gpioBMeta <= io_pads_gpioB_i_ival;
         r_gpioBIn   <= r_gpioBMeta;
      end
   end

   // Bus accesses are held off until the synchronised reset has released.
   assign w_wrEn = bus.bus_valid &  bus.bus_write & r_rstSync[1];
   assign w_rdEn = bus.bus_valid & ~bus.bus_write & r_rstSync[1];

   always_ff @(posedge hfextclk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_gpioAOut <= '0;
         r_gpioAOe  <= '0;
         r_gpioBOut <= '0;
         r_gpioBOe  <= '0;
      end else if (w_wrEn) begin
         case (w_wordAddr)
            A_GPIOA_OUT: r_gpioAOut <= bus.bus_wdata[GPIO_W-1:0];
            A_GPIOA_OE:  r_gpioAOe  <= bus.bus_wdata[GPIO_W-1:0];
            A_GPIOB_OUT: r_gpioBOut <= bus.bus_wdata[GPIO_W-1:0];
            A_GPIOB_OE:  r_gpioBOe  <= bus.bus_wdata[GPIO_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      w_readData = 32'd0;
      case (w_wordAddr)
         A_GPIOA_OUT: w_readData = 32'(r_gpioAOut);
         A_GPIOA_OE:  w_readData = 32'(r_gpioAOe);
         A_GPIOA_IN:  w_readData = 32'(r_gpioAIn);
         A_GPIOB_OUT: w_readData = 32'(r_gpioBOut);
         A_GPIOB_OE:  w_readData = 32'(r_gpioBOe);
         A_GPIOB_IN:  w_readData = 32'(r_gpioBIn);
         A_MODE:      w_readData = {27'd0, dbg_mode, r_wakeSync[1], w_bootromN};
         default:     w_readData = 32'd0;
      endcase
   end

   // Read data samples pre-edge register values, so a same-edge write is not seen.
   always_ff @(posedge hfextclk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_rdata <= 32'd0;
      end else if (w_rdEn) begin
         r_rdata <= w_readData;
      end
   end

   assign bus.bus_rdata = r_rdata;
   assign bus.bus_ready = 1'b1;

   assign io_pads_gpioA_o_oval = r_gpioAOut;
   assign io_pads_gpioA_o_oe   = r_gpioAOe;
   assign io_pads_gpioB_o_oval = r_gpioBOut;
   assign io_pads_gpioB_o_oe   = r_gpioBOe;

   assign jtag_tck                = io_pads_jtag_TCK_i_ival;
   assign jtag_tms                = io_pads_jtag_TMS_i_ival;
   assign jtag_tdi                = io_pads_jtag_TDI_i_ival;
   assign io_pads_jtag_TDO_o_oval = jtag_tdo;
   assign io_pads_jtag_TDO_o_oe   = jtag_tdo_oe;

   assign io_pads_qspi0_sck_o_oval  = qspi_sck;
   assign io_pads_qspi0_cs_0_o_oval = qspi_cs;
   assign io_pads_qspi0_dq_0_o_oval = qspi_dq_o[0];
   assign io_pads_qspi0_dq_1_o_oval = qspi_dq_o[1];
   assign io_pads_qspi0_dq_2_o_oval = qspi_dq_o[2];
   assign io_pads_qspi0_dq_3_o_oval = qspi_dq_o[3];
   assign io_pads_qspi0_dq_0_o_oe   = qspi_dq_oe[0];
   assign io_pads_qspi0_dq_1_o_oe   = qspi_dq_oe[1];
   assign io_pads_qspi0_dq_2_o_oe   = qspi_dq_oe[2];
   assign io_pads_qspi0_dq_3_o_oe   = qspi_dq_oe[3];
   assign qspi_dq_i = {io_pads_qspi0_dq_3_i_ival, io_pads_qspi0_dq_2_i_ival,
                       io_pads_qspi0_dq_1_i_ival, io_pads_qspi0_dq_0_i_ival};

endmodule

// File: tb/tb_e203_soc_pad_ctrl.sv
// Directed bench for e203_soc_pad_ctrl: reset, straps, GPIO registers,
// MODE register and JTAG/QSPI pass-through with hand-computed expectations.
module tb_e203_soc_pad_ctrl;

   logic        hfextclk;
   logic        rstN;
   logic        hfxoscen, lfxoscen;
   logic        bootromN, dbg0N, dbg1N, dbg2N;
   logic        dwakeupN, vddpaden, padrst;
   logic [31:0] gpioAIn, gpioBIn, gpioAOut, gpioBOut, gpioAOe, gpioBOe;
   logic        tckPad, tmsPad, tdiPad, tdoPad, tdoPadOe;
   logic        jtagTck, jtagTms, jtagTdi, jtagTdo, jtagTdoOe;
   logic        qspiSckPad, qspiCsPad;
   logic [3:0]  dqPadIn, dqPadOut, dqPadOe;
   logic        qspiSck, qspiCs;
   logic [3:0]  qspiDqO, qspiDqOe, qspiDqI;
   logic        sysRstN;
   logic [31:0] resetVector;
   logic [2:0]  dbgMode;
   logic        wakeup;

   int errorCount = 0;
   int checkCount = 0;
   logic [31:0] readValue;

   e203_soc_pad_ctrl_if busIf ();

   e203_soc_pad_ctrl dut (
      .hfextclk                         (hfextclk),
      .io_pads_aon_erst_n_i_ival        (rstN),
      .bus                              (busIf),
      .hfxoscen                         (hfxoscen),
      .lfxoscen                         (lfxoscen),
      .io_pads_bootrom_n_i_ival         (bootromN),
      .io_pads_dbgmode0_n_i_ival        (dbg0N),
      .io_pads_dbgmode1_n_i_ival        (dbg1N),
      .io_pads_dbgmode2_n_i_ival        (dbg2N),
      .io_pads_aon_pmu_dwakeup_n_i_ival (dwakeupN),
      .io_pads_aon_pmu_vddpaden_o_oval  (vddpaden),
      .io_pads_aon_pmu_padrst_o_oval    (padrst),
      .io_pads_gpioA_i_ival             (gpioAIn),
      .io_pads_gpioB_i_ival             (gpioBIn),
      .io_pads_gpioA_o_oval             (gpioAOut),
      .io_pads_gpioB_o_oval             (gpioBOut),
      .io_pads_gpioA_o_oe               (gpioAOe),
      .io_pads_gpioB_o_oe               (gpioBOe),
      .io_pads_jtag_TCK_i_ival          (tckPad),
      .io_pads_jtag_TMS_i_ival          (tmsPad),
      .io_pads_jtag_TDI_i_ival          (tdiPad),
      .io_pads_jtag_TDO_o_oval          (tdoPad),
      .io_pads_jtag_TDO_o_oe            (tdoPadOe),
      .jtag_tck                         (jtagTck),
      .jtag_tms                         (jtagTms),
      .jtag_tdi                         (jtagTdi),
      .jtag_tdo                         (jtagTdo),
      .jtag_tdo_oe                      (jtagTdoOe),
      .io_pads_qspi0_sck_o_oval         (qspiSckPad),
      .io_pads_qspi0_cs_0_o_oval        (qspiCsPad),
      .io_pads_qspi0_dq_0_i_ival        (dqPadIn[0]),
      .io_pads_qspi0_dq_1_i_ival        (dqPadIn[1]),
      .io_pads_qspi0_dq_2_i_ival        (dqPadIn[2]),
      .io_pads_qspi0_dq_3_i_ival        (dqPadIn[3]),
      .io_pads_qspi0_dq_0_o_oval        (dqPadOut[0]),
      .io_pads_qspi0_dq_1_o_oval        (dqPadOut[1]),
      .io_pads_qspi0_dq_2_o_oval        (dqPadOut[2]),
      .io_pads_qspi0_dq_3_o_oval        (dqPadOut[3]),
      .io_pads_qspi0_dq_0_o_oe          (dqPadOe[0]),
      .io_pads_qspi0_dq_1_o_oe          (dqPadOe[1]),
      .io_pads_qspi0_dq_2_o_oe          (dqPadOe[2]),
      .io_pads_qspi0_dq_3_o_oe          (dqPadOe[3]),
      .qspi_sck                         (qspiSck),
      .qspi_cs                          (qspiCs),
      .qspi_dq_o                        (qspiDqO),
      .qspi_dq_oe                       (qspiDqOe),
      .qspi_dq_i                        (qspiDqI),
      .sys_rst_n                        (sysRstN),
      .reset_vector                     (resetVector),
      .dbg_mode                         (dbgMode),
      .wakeup                           (wakeup)
   );

   initial hfextclk = 1'b0;
   always #5 hfextclk = ~hfextclk;

   // Compares one observed value against its expected value and tallies it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One bus transfer, issued on a falling edge and retired on the next one.
   task automatic applyStimulus(input logic isWrite, input logic [4:0] addr,
                                input logic [31:0] data, output logic [31:0] rdata);
      busIf.bus_valid = 1'b1;
      busIf.bus_write = isWrite;
      busIf.bus_addr  = addr;
      busIf.bus_wdata = data;
      @(negedge hfextclk);
      busIf.bus_valid = 1'b0;
      busIf.bus_write = 1'b0;
      rdata = busIf.bus_rdata;
   endtask

   initial begin
      rstN       = 1'b0;
      bootromN   = 1'b0;
      dbg0N      = 1'b1;
      dbg1N      = 1'b1;
      dbg2N      = 1'b1;
      dwakeupN   = 1'b1;
      gpioAIn    = '0;
      gpioBIn    = '0;
      tckPad     = 1'b0;
      tmsPad     = 1'b0;
      tdiPad     = 1'b0;
      jtagTdo    = 1'b0;
      jtagTdoOe  = 1'b0;
      dqPadIn    = '0;
      qspiSck    = 1'b0;
      qspiCs     = 1'b0;
      qspiDqO    = '0;
      qspiDqOe   = '0;
      busIf.bus_valid = 1'b0;
      busIf.bus_write = 1'b0;
      busIf.bus_addr  = '0;
      busIf.bus_wdata = '0;

      // Reset held for 120 time units with the clock running.
      repeat (12) @(negedge hfextclk);
      checkOutput("rst gpioA_out", gpioAOut, 32'h0);
      checkOutput("rst gpioA_oe",  gpioAOe,  32'h0);
      checkOutput("rst gpioB_out", gpioBOut, 32'h0);
      checkOutput("rst gpioB_oe",  gpioBOe,  32'h0);
      checkOutput("rst padrst",    {31'd0, padrst},   32'h1);
      checkOutput("rst sys_rst_n", {31'd0, sysRstN},  32'h0);
      checkOutput("rst rdata",     busIf.bus_rdata,   32'h0);
      checkOutput("rst wakeup",    {31'd0, wakeup},   32'h0);
      checkOutput("rst vec",       resetVector,       32'h8000_0000);
      checkOutput("static pins",   {28'd0, hfxoscen, lfxoscen, vddpaden, busIf.bus_ready}, 32'hF);

      rstN = 1'b1;
      @(negedge hfextclk);
      checkOutput("sync edge1",    {31'd0, sysRstN}, 32'h0);
      @(negedge hfextclk);
      checkOutput("sync edge2",    {31'd0, sysRstN}, 32'h1);
      checkOutput("padrst low",    {31'd0, padrst},  32'h0);

      repeat (2) @(negedge hfextclk);
      bootromN = 1'b1;
      #1;
      checkOutput("vec held",      resetVector, 32'h8000_0000);
      bootromN = 1'b0;

      // GPIO A registers
      @(negedge hfextclk);
      applyStimulus(1'b1, 5'h00, 32'hA5A5_5A5A, readValue);
      applyStimulus(1'b1, 5'h04, 32'hFFFF_0000, readValue);
      checkOutput("gpioA pad out", gpioAOut, 32'hA5A5_5A5A);
      checkOutput("gpioA pad oe",  gpioAOe,  32'hFFFF_0000);
      applyStimulus(1'b0, 5'h00, 32'h0, readValue);
      checkOutput("rd gpioA out",  readValue, 32'hA5A5_5A5A);
      @(negedge hfextclk);
      checkOutput("rdata hold",    busIf.bus_rdata, 32'hA5A5_5A5A);
      applyStimulus(1'b0, 5'h07, 32'h0, readValue);
      checkOutput("rd gpioA oe lowbits", readValue, 32'hFFFF_0000);

      // GPIO B registers
      applyStimulus(1'b1, 5'h0C, 32'h0F0F_0F0F, readValue);
      applyStimulus(1'b1, 5'h10, 32'h0000_00FF, readValue);
      checkOutput("gpioB pad out", gpioBOut, 32'h0F0F_0F0F);
      checkOutput("gpioB pad oe",  gpioBOe,  32'h0000_00FF);
      applyStimulus(1'b0, 5'h10, 32'h0, readValue);
      checkOutput("rd gpioB oe",   readValue, 32'h0000_00FF);

      // GPIO input synchroniser latency
      gpioAIn = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 5'h08, 32'h0, readValue);
      checkOutput("gpioA in early", readValue, 32'h0);
      gpioBIn = 32'h1234_5678;
      repeat (2) @(negedge hfextclk);
      applyStimulus(1'b0, 5'h14, 32'h0, readValue);
      checkOutput("rd gpioB in",   readValue, 32'h1234_5678);
      applyStimulus(1'b0, 5'h08, 32'h0, readValue);
      checkOutput("rd gpioA in",   readValue, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 5'h14, 32'hFFFF_FFFF, readValue);
      applyStimulus(1'b0, 5'h14, 32'h0, readValue);
      checkOutput("ro write ign",  readValue, 32'h1234_5678);
      checkOutput("ro no side",    gpioBOut,  32'h0F0F_0F0F);

      // MODE and unmapped address
      applyStimulus(1'b0, 5'h18, 32'h0, readValue);
      checkOutput("mode idle",     readValue, 32'h0);
      applyStimulus(1'b0, 5'h1C, 32'h0, readValue);
      checkOutput("addr7 zero",    readValue, 32'h0);
      dwakeupN = 1'b0;
      repeat (2) @(negedge hfextclk);
      checkOutput("wakeup sync",   {31'd0, wakeup}, 32'h1);
      applyStimulus(1'b0, 5'h18, 32'h0, readValue);
      checkOutput("mode wakeup",   readValue, 32'h2);
      dwakeupN = 1'b1;

      // Mid-operation reset with flash boot and debug mode 0 strapped.
      bootromN = 1'b1;
      dbg0N    = 1'b0;
      rstN     = 1'b0;
      #1;
      checkOutput("mid rst sys",   {31'd0, sysRstN}, 32'h0);
      checkOutput("mid rst gpioA", gpioAOut,         32'h0);
      checkOutput("mid rst rdata", busIf.bus_rdata,  32'h0);
      checkOutput("mid rst vec",   resetVector,      32'h2000_0000);
      repeat (3) @(negedge hfextclk);
      rstN = 1'b1;
      repeat (4) @(negedge hfextclk);
      bootromN = 1'b0;
      dbg0N    = 1'b1;
      #1;
      checkOutput("flash vec held", resetVector, 32'h2000_0000);
      checkOutput("dbg_mode",       {29'd0, dbgMode}, 32'h1);
      @(negedge hfextclk);
      applyStimulus(1'b0, 5'h18, 32'h0, readValue);
      checkOutput("mode dbg0",     readValue, 32'h5);

      // JTAG / QSPI pass-through
      #1;
      checkOutput("jtag in zero",  {29'd0, jtagTck, jtagTms, jtagTdi}, 32'h0);
      tckPad    = 1'b1;
      tdiPad    = 1'b1;
      jtagTdo   = 1'b1;
      jtagTdoOe = 1'b1;
      qspiSck   = 1'b1;
      qspiDqO   = 4'b1010;
      qspiDqOe  = 4'b0110;
      dqPadIn   = 4'b1001;
      #1;
      checkOutput("jtag in pass",  {29'd0, jtagTck, jtagTms, jtagTdi}, 32'h5);
      checkOutput("tdo pass",      {30'd0, tdoPad, tdoPadOe}, 32'h3);
      checkOutput("qspi ctl",      {30'd0, qspiSckPad, qspiCsPad}, 32'h2);
      checkOutput("qspi dq out",   {28'd0, dqPadOut}, 32'hA);
      checkOutput("qspi dq oe",    {28'd0, dqPadOe},  32'h6);
      checkOutput("qspi dq in",    {28'd0, qspiDqI},  32'h9);
      qspiCs   = 1'b1;
      jtagTdo  = 1'b0;
      qspiDqO  = 4'b0101;
      dqPadIn  = 4'b0110;
      #1;
      checkOutput("tdo pass2",     {30'd0, tdoPad, tdoPadOe}, 32'h1);
      checkOutput("qspi ctl2",     {30'd0, qspiSckPad, qspiCsPad}, 32'h3);
      checkOutput("qspi dq out2",  {28'd0, dqPadOut}, 32'h5);
      checkOutput("qspi dq in2",   {28'd0, qspiDqI},  32'h6);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/e203_soc_pad_ctrl.md
Name: e203_soc_pad_ctrl

Overview:
- Pad-facing control shell of the E203 SoC, between the chip pads and the core/peripheral subsystem.
- Provides reset synchronisation, boot-vector and debug-mode decode, and GPIO A/B pad registers behind a simple register bus.
- Passes JTAG/QSPI pad signals through to the core side.
- Oscillator and PMU pad outputs are static or reset-derived.

Parameters:
- GPIO_W, 32, width of each GPIO bank.
- ROM_VEC, 32'h8000_0000, reset vector when bootrom_n=0 (ITCM boot).
- FLASH_VEC, 32'h2000_0000, reset vector when bootrom_n=1 (flash boot).

Ports:
- hfextclk  in  1  sole clock.
- io_pads_aon_erst_n_i_ival  in  1  asynchronous active-low reset.
- hfxoscen  out  1  HF oscillator enable, constant 1.
- lfxoscen  out  1  LF oscillator enable, constant 1.
- io_pads_bootrom_n_i_ival  in  1  boot select.
- io_pads_dbgmode0_n_i_ival / io_pads_dbgmode1_n_i_ival / io_pads_dbgmode2_n_i_ival  in  1 each  active-low debug-mode straps.
- io_pads_aon_pmu_dwakeup_n_i_ival  in  1  wakeup pad.
- io_pads_aon_pmu_vddpaden_o_oval  out  1  pad VDD enable.
- io_pads_aon_pmu_padrst_o_oval  out  1  pad reset.
- io_pads_gpioA_i_ival / io_pads_gpioB_i_ival  in  32 each  GPIO pad inputs.
- io_pads_gpioA_o_oval / io_pads_gpioB_o_oval  out  32 each  GPIO pad outputs.
- io_pads_gpioA_o_oe / io_pads_gpioB_o_oe  out  32 each  GPIO output enables.
- io_pads_jtag_TCK_i_ival / io_pads_jtag_TMS_i_ival / io_pads_jtag_TDI_i_ival  in  1 each  JTAG pads.
- io_pads_jtag_TDO_o_oval  out  1  TDO pad; io_pads_jtag_TDO_o_oe  out  1  TDO enable.
- jtag_tck / jtag_tms / jtag_tdi  out  1 each  core-side JTAG.
- jtag_tdo / jtag_tdo_oe  in  1 each  core-side TDO.
- io_pads_qspi0_sck_o_oval / io_pads_qspi0_cs_0_o_oval  out  1 each  QSPI clock/chip-select.
- io_pads_qspi0_dq_N_i_ival  in  1  QSPI data pad input, N=0..3.
- io_pads_qspi0_dq_N_o_oval  out  1  QSPI data pad output, N=0..3.
- io_pads_qspi0_dq_N_o_oe  out  1  QSPI data pad enable, N=0..3.
- qspi_sck / qspi_cs  in  1 each  core-side QSPI.
- qspi_dq_o / qspi_dq_oe  in  4 each  core-side QSPI data out/enable.
- qspi_dq_i  out  4  core-side QSPI data in.
- sys_rst_n  out  1  synchronised reset to subsystem.
- reset_vector  out  32  core boot PC.
- dbg_mode  out  3  decoded debug mode.
- wakeup  out  1  synchronised wakeup.
- bus_valid  in  1; bus_write  in  1; bus_addr  in  5; bus_wdata  in  32.
- bus_rdata  out  32; bus_ready  out  1.

Behaviour:
- Reset sync: 2-flop chain on hfextclk, async clear by reset low.
  - sys_rst_n = 0 immediately on assert.
  - sys_rst_n = 1 on the 2nd rising edge after release.
  - Reset mid-operation clears all registers at once.
- Pad reset: io_pads_aon_pmu_padrst_o_oval = ~sys_rst_n; io_pads_aon_pmu_vddpaden_o_oval = 1 always.
- Boot straps: bootrom_n and the dbgmode straps are latched into registers on the first clock where sys_rst_n=1, and held thereafter.
  - reset_vector = latched bootrom_n ? FLASH_VEC : ROM_VEC.
  - dbg_mode = ~{dbgmode2_n, dbgmode1_n, dbgmode0_n}, latched.
  - During reset the latch follows the pads combinationally, so reset_vector reflects the live pad.
- wakeup: ~dwakeup_n through a 2-flop synchroniser, reset value 0.
- JTAG and QSPI: pure combinational pass-through, no registers.
  - TDO_o_oval = jtag_tdo; TDO_o_oe = jtag_tdo_oe.
  - qspi_dq_i = {dq_3 … dq_0} pad inputs.
- Register map (word addresses, bus_addr[4:2]; bus_addr[1:0] ignored):
  - 0 GPIOA_OUT (rw)
  - 1 GPIOA_OE (rw)
  - 2 GPIOA_IN (ro, 2-flop synchronised pads)
  - 3 GPIOB_OUT (rw)
  - 4 GPIOB_OE (rw)
  - 5 GPIOB_IN (ro)
  - 6 MODE (ro) = {27'b0, dbg_mode[2:0], wakeup, latched bootrom_n}
  - 7 reads 0
- Register reset values: OUT/OE registers reset to 0; pad outputs equal the registers directly.
- Bus timing:
  - bus_ready = 1 always.
  - Write commits on the edge where bus_valid & bus_write; writes to read-only addresses are ignored.
  - Read: bus_rdata is registered, valid one cycle after bus_valid & ~bus_write, and holds its value until the next read. Reset value 0.
- Simultaneous write and read of the same register: the read returns the old value.
- GPIO input latency: pad change is visible in the IN register 2 cycles later, readable on the 3rd.

Test Plan:
- Reset: hold reset low 120 time units with clock toggling → all OUT/OE = 0, padrst = 1, bus_rdata = 0. Release → sys_rst_n rises on the 2nd edge, padrst falls with it.
- Boot strap: bootrom_n = 0 at release → reset_vector = 32'h8000_0000. Toggle the pad to 1 after release → the vector stays; a new reset with pad = 1 → 32'h2000_0000.
- GPIO write/readback: write 0xA5A5_5A5A to addr 0x00 and 0xFFFF_0000 to 0x04 → gpioA_o_oval and gpioA_o_oe match; read 0x00 → 0xA5A5_5A5A one cycle later.
- GPIO input: drive gpioB pads = 0x1234_5678, read 0x14 after 3 cycles → 0x1234_5678. Write 0x14 → ignored.
- MODE: dbgmode n-straps = 1,1,1, bootrom_n = 0, dwakeup_n = 1 → read 0x18 = 0. Dbgmode0_n = 0 at reset → bit 2 set (value 4).
- Pass-through: toggle jtag_tdo/qspi_dq_o/qspi_dq_oe and dq pads → pad/core outputs follow in the same cycle. JTAG inputs tied 0 → jtag_tck/tms/tdi = 0.
